// File: rtl/axi4_rd_arbiter_if.sv
// Bus bundle for the read arbiter: packed per-master AR/R signals on the upstream
// side and a single AXI4 read port on the downstream side.
interface axi4_rd_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ID_WIDTH    = 8
);
  logic [NUM_MASTERS-1:0]            s_arvalid;
  logic [NUM_MASTERS-1:0]            s_arready;
  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_arid;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_MASTERS*8-1:0]          s_arlen;
  logic [NUM_MASTERS*3-1:0]          s_arsize;
  logic [NUM_MASTERS*2-1:0]          s_arburst;
  logic [NUM_MASTERS-1:0]            s_rvalid;
  logic [NUM_MASTERS-1:0]            s_rready;
  logic [ID_WIDTH-1:0]               s_rid;
  logic [DATA_WIDTH-1:0]             s_rdata;
  logic [1:0]                        s_rresp;
  logic                              s_rlast;

  logic                              m_arvalid;
  logic                              m_arready;
  logic [ID_WIDTH-1:0]               m_arid;
  logic [ADDR_WIDTH-1:0]             m_araddr;
  logic [7:0]                        m_arlen;
  logic [2:0]                        m_arsize;
  logic [1:0]                        m_arburst;
  logic                              m_rvalid;
  logic                              m_rready;
  logic [ID_WIDTH-1:0]               m_rid;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [1:0]                        m_rresp;
  logic                              m_rlast;

  // Arbiter view: slave to the upstream masters, master to the downstream port.
  modport slave (
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    output s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    input  m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
  );

  // Environment view: upstream requesters plus the downstream memory model.
  modport master (
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_rready,
    input  s_arready, s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    output m_arready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
  );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// Round-robin AXI4 read arbiter: one burst in flight, R beats routed to the owner
// until rlast, with a sticky beat-count protocol error.
module axi4_rd_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned ID_WIDTH    = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  axi4_rd_arbiter_if.slave                 bus,
  output logic                             busy,
  output logic [$clog2(NUM_MASTERS)-1:0]   grant_idx,
  output logic                             protocol_err
);
  localparam int unsigned GIDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                  state_q, state_d;
  logic [GIDX_W-1:0]       last_q, last_d;
  logic [GIDX_W-1:0]       grant_q, grant_d;
  logic                    arvalid_q, arvalid_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [8:0]              beat_q, beat_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic [GIDX_W-1:0]       win, idx;
  logic                    found;
  logic                    beat_xfer;

  // Read data payload is a straight pass-through; only valid/ready are steered.
  assign bus.s_rid   = bus.m_rid;
  assign bus.s_rdata = bus.m_rdata;
  assign bus.s_rresp = bus.m_rresp;
  assign bus.s_rlast = bus.m_rlast;

  assign bus.m_arvalid = arvalid_q;
  assign bus.m_arid    = id_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = len_q;
  assign bus.m_arsize  = size_q;
  assign bus.m_arburst = burst_q;
  assign busy          = busy_q;
  assign grant_idx     = grant_q;
  assign protocol_err  = err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      last_q    <= GIDX_W'(NUM_MASTERS - 1);
      grant_q   <= '0;
      arvalid_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      arvalid_q <= arvalid_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_d       = grant_q;
    arvalid_d     = arvalid_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    size_d        = size_q;
    burst_d       = burst_q;
    beat_d        = beat_q;
    err_d         = err_q;
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.m_rready  = 1'b0;
    found         = 1'b0;
    win           = '0;
    idx           = '0;
    beat_xfer     = 1'b0;

    // Walk from farthest to nearest so the nearest requester after last_q wins.
    for (int k = int'(NUM_MASTERS); k >= 1; k--) begin
      idx = GIDX_W'((32'(last_q) + 32'(k)) % NUM_MASTERS);
      if (bus.s_arvalid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          bus.s_arready[win] = 1'b1;
          id_d      = bus.s_arid[32'(win)*ID_WIDTH +: ID_WIDTH];
          addr_d    = bus.s_araddr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          len_d     = bus.s_arlen[32'(win)*8 +: 8];
          size_d    = bus.s_arsize[32'(win)*3 +: 3];
          burst_d   = bus.s_arburst[32'(win)*2 +: 2];
          last_d    = win;
          grant_d   = win;
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (arvalid_q && bus.m_arready) begin
          arvalid_d = 1'b0;
          beat_d    = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        bus.s_rvalid[grant_q] = bus.m_rvalid;
        bus.m_rready          = bus.s_rready[grant_q];
        beat_xfer             = bus.m_rvalid && bus.s_rready[grant_q];
        if (beat_xfer) begin
          beat_d = beat_q + 9'd1;
          // Early rlast and missing rlast on the final beat both flag the error.
          if (bus.m_rlast) begin
            if (beat_q != {1'b0, len_q}) err_d = 1'b1;
            state_d = IDLE;
          end else if (beat_q == {1'b0, len_q}) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter: single burst, round-robin order, backpressure,
// beat-count errors, stray read data and reset mid-burst.
module tb_axi4_rd_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned IW = 8;

  logic       aclk;
  logic       areset;
  logic       busy;
  logic [1:0] grant_idx;
  logic       protocol_err;
  int         checks;
  int         errors;

  axi4_rd_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi4_rd_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .aclk(aclk), .areset(areset), .bus(bus),
    .busy(busy), .grant_idx(grant_idx), .protocol_err(protocol_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [63:0] addr, input logic [7:0] len,
                         input logic [7:0] id);
    bus.s_arvalid[i]             = 1'b1;
    bus.s_araddr[i*AW +: AW]     = addr;
    bus.s_arlen[i*8 +: 8]        = len;
    bus.s_arid[i*IW +: IW]       = id;
    bus.s_arsize[i*3 +: 3]       = 3'd6;
    bus.s_arburst[i*2 +: 2]      = 2'b01;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Present one R beat, check routing, and let it transfer on the next edge.
  task automatic beat(input int m, input logic [63:0] d, input logic last);
    logic [63:0] onehot;
    onehot         = 64'(1) << m;
    bus.m_rvalid   = 1'b1;
    bus.m_rdata    = DW'(d);
    bus.m_rlast    = last;
    #1;
    chk("beat_s_rvalid", 64'(bus.s_rvalid), onehot);
    chk("beat_m_rready", 64'(bus.m_rready), 64'd1);
    chk("beat_s_rdata", bus.s_rdata[63:0], d);
    chk("beat_s_rlast", 64'(bus.s_rlast), 64'(last));
    tick();
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;
  endtask

  // IDLE-cycle handshake for the expected winner, then land in ADDR.
  task automatic grant(input int m, input logic [63:0] addr);
    logic [63:0] onehot;
    onehot = 64'(1) << m;
    #1;
    chk("s_arready_win", 64'(bus.s_arready), onehot);
    tick();
    chk("grant_idx", 64'(grant_idx), 64'(m));
    chk("m_arvalid_addr", 64'(bus.m_arvalid), 64'd1);
    chk("m_araddr", bus.m_araddr, addr);
    chk("s_arready_addr", 64'(bus.s_arready), 64'd0);
    chk("busy_addr", 64'(busy), 64'd1);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    areset         = 1'b1;
    bus.s_arvalid  = '0;
    bus.s_arid     = '0;
    bus.s_araddr   = '0;
    bus.s_arlen    = '0;
    bus.s_arsize   = '0;
    bus.s_arburst  = '0;
    bus.s_rready   = '1;
    bus.m_arready  = 1'b1;
    bus.m_rvalid   = 1'b0;
    bus.m_rid      = 8'h5a;
    bus.m_rdata    = '0;
    bus.m_rresp    = 2'b00;
    bus.m_rlast    = 1'b0;
    do_reset();

    chk("rst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);
    chk("rst_s_rvalid", 64'(bus.s_rvalid), 64'd0);

    // Single request from master 2, arlen=3.
    set_req(2, 64'h1000, 8'd3, 8'h22);
    grant(2, 64'h1000);
    bus.s_arvalid = '0;
    chk("single_m_arid", 64'(bus.m_arid), 64'h22);
    chk("single_m_arlen", 64'(bus.m_arlen), 64'd3);
    tick();
    chk("single_arvalid_cleared", 64'(bus.m_arvalid), 64'd0);
    chk("single_busy_data", 64'(busy), 64'd1);
    for (int b = 0; b < 4; b++) beat(2, 64'(100 + b), b == 3);
    chk("single_busy_done", 64'(busy), 64'd0);
    chk("single_protocol_err", 64'(protocol_err), 64'd0);

    // Round-robin from reset with all masters requesting single beats.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 64'(i * 256), 8'd0, 8'(i));
    for (int g = 0; g < 6; g++) begin
      grant(g % 4, 64'((g % 4) * 256));
      tick();
      chk("rr_busy_data", 64'(busy), 64'd1);
      beat(g % 4, 64'(g), 1'b1);
      chk("rr_busy_idle", 64'(busy), 64'd0);
    end
    bus.s_arvalid = '0;

    // Backpressure: slave holds off AR 5 cycles, then master 1 stalls R 3 cycles.
    bus.m_arready = 1'b0;
    set_req(1, 64'hABC0, 8'd2, 8'h11);
    grant(1, 64'hABC0);
    bus.s_arvalid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_m_arvalid", 64'(bus.m_arvalid), 64'd1);
      chk("bp_m_araddr", bus.m_araddr, 64'hABC0);
      chk("bp_m_arlen", 64'(bus.m_arlen), 64'd2);
      if (c == 4) bus.m_arready = 1'b1;
      tick();
    end
    chk("bp_arvalid_cleared", 64'(bus.m_arvalid), 64'd0);
    beat(1, 64'hB0, 1'b0);
    bus.s_rready[1] = 1'b0;
    bus.m_rvalid    = 1'b1;
    bus.m_rdata     = DW'(64'hB1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_m_rready_low", 64'(bus.m_rready), 64'd0);
      chk("bp_s_rvalid", 64'(bus.s_rvalid), 64'd2);
      tick();
    end
    bus.s_rready[1] = 1'b1;
    beat(1, 64'hB1, 1'b0);
    beat(1, 64'hB2, 1'b1);
    chk("bp_busy_done", 64'(busy), 64'd0);
    chk("bp_protocol_err", 64'(protocol_err), 64'd0);

    // Beat error: arlen=3 but rlast arrives on beat 1.
    set_req(0, 64'h2000, 8'd3, 8'h00);
    grant(0, 64'h2000);
    bus.s_arvalid = '0;
    tick();
    beat(0, 64'hC0, 1'b0);
    chk("err_before", 64'(protocol_err), 64'd0);
    beat(0, 64'hC1, 1'b1);
    chk("err_set", 64'(protocol_err), 64'd1);
    chk("err_busy_idle", 64'(busy), 64'd0);
    set_req(3, 64'h3000, 8'd1, 8'h33);
    grant(3, 64'h3000);
    bus.s_arvalid = '0;
    tick();
    beat(3, 64'hD0, 1'b0);
    beat(3, 64'hD1, 1'b1);
    chk("err_sticky", 64'(protocol_err), 64'd1);
    chk("err_next_done", 64'(busy), 64'd0);

    // Stray read data while idle with no requests.
    bus.m_rvalid = 1'b1;
    bus.m_rlast  = 1'b1;
    #1;
    chk("stray_m_rready", 64'(bus.m_rready), 64'd0);
    chk("stray_s_rvalid", 64'(bus.s_rvalid), 64'd0);
    tick();
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_grant_idx", 64'(grant_idx), 64'd3);
    chk("stray_m_arvalid", 64'(bus.m_arvalid), 64'd0);
    bus.m_rvalid = 1'b0;
    bus.m_rlast  = 1'b0;

    // Reset mid-burst after two of eight beats.
    set_req(2, 64'h4000, 8'd7, 8'h44);
    grant(2, 64'h4000);
    bus.s_arvalid = '0;
    tick();
    beat(2, 64'hE0, 1'b0);
    beat(2, 64'hE1, 1'b0);
    areset       = 1'b1;
    bus.m_rvalid = 1'b1;
    tick();
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_grant_idx", 64'(grant_idx), 64'd0);
    chk("mrst_protocol_err", 64'(protocol_err), 64'd0);
    chk("mrst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
    chk("mrst_s_rvalid", 64'(bus.s_rvalid), 64'd0);
    chk("mrst_m_rready", 64'(bus.m_rready), 64'd0);
    areset       = 1'b0;
    bus.m_rvalid = 1'b0;
    set_req(3, 64'h5000, 8'd0, 8'h35);
    grant(3, 64'h5000);
    bus.s_arvalid = '0;
    tick();
    beat(3, 64'hF0, 1'b1);
    chk("mrst_final_busy", 64'(busy), 64'd0);
    chk("mrst_final_err", 64'(protocol_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_rd_arbiter.md
Name: axi4_rd_arbiter

Overview:
- Round-robin arbiter that shares one AXI4 read port (AR + R channels) among NUM_MASTERS upstream requesters. It feeds the memory/peripheral slave side of the AXI4 fabric.
- Exactly one burst is in flight at a time: grant AR, route all R beats to the owner until rlast, then re-arbitrate.
- Also checks beat count against arlen and exposes a sticky protocol error.

Parameters:
- NUM_MASTERS, 4, number of upstream read requesters (2..8)
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 512, read data width
- ID_WIDTH, 8, transaction ID width; passed through unchanged, no prefixing

Ports:
- aclk  in  1  clock, all logic rising-edge
- areset  in  1  synchronous, active-high reset
- s_arvalid  in  NUM_MASTERS  per-master AR valid
- s_arready  out  NUM_MASTERS  per-master AR ready
- s_arid  in  NUM_MASTERS*ID_WIDTH  packed; master i at [i*ID_WIDTH +: ID_WIDTH]
- s_araddr  in  NUM_MASTERS*ADDR_WIDTH  packed per master
- s_arlen  in  NUM_MASTERS*8  packed per master
- s_arsize  in  NUM_MASTERS*3  packed per master
- s_arburst  in  NUM_MASTERS*2  packed per master
- s_rvalid  out  NUM_MASTERS  per-master R valid
- s_rready  in  NUM_MASTERS  per-master R ready
- s_rid  out  ID_WIDTH  broadcast to all masters
- s_rdata  out  DATA_WIDTH  broadcast to all masters
- s_rresp  out  2  broadcast to all masters
- s_rlast  out  1  broadcast to all masters
- m_arvalid  out  1  downstream AR valid
- m_arready  in  1  downstream AR ready
- m_arid  out  ID_WIDTH  downstream AR ID
- m_araddr  out  ADDR_WIDTH  downstream AR address
- m_arlen  out  8  downstream AR length
- m_arsize  out  3  downstream AR size
- m_arburst  out  2  downstream AR burst type
- m_rvalid  in  1  downstream R valid
- m_rready  out  1  downstream R ready
- m_rid  in  ID_WIDTH  downstream R ID
- m_rdata  in  DATA_WIDTH  downstream R data
- m_rresp  in  2  downstream R response
- m_rlast  in  1  downstream R last
- busy  out  1  high in ADDR or DATA
- grant_idx  out  $clog2(NUM_MASTERS)  current/last owner
- protocol_err  out  1  sticky beat-count error

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset state IDLE.
- Reset values: m_arvalid=0, all s_arready=0, all s_rvalid=0, m_rready=0, busy=0, grant_idx=0, protocol_err=0, last_grant=NUM_MASTERS-1 (so master 0 has top priority first). The AR payload register resets to 0.
- Reset mid-burst: return to IDLE immediately. The outstanding downstream burst is abandoned; the integration top resets the slave together with this block.
- IDLE arbitration:
  - Search starts at (last_grant+1) mod NUM_MASTERS and wraps.
  - The first master with s_arvalid=1 wins; s_arready[win]=1 combinationally in that same cycle, all other s_arready=0.
  - The handshake completes that cycle. The winner's payload is latched, last_grant and grant_idx update to win, and the FSM goes to ADDR.
  - No requests: stay in IDLE, last_grant unchanged.
- ADDR:
  - m_arvalid=1 with the latched payload, held stable until m_arready.
  - Latency: upstream handshake in cycle t gives m_arvalid=1 in cycle t+1. If m_arready=1 in t+1, the FSM is in DATA at t+2.
  - On m_arvalid & m_arready: clear m_arvalid, clear beat counter, go to DATA.
  - s_arready=0 for all masters in ADDR and DATA.
- DATA routing:
  - s_rvalid[grant_idx]=m_rvalid; m_rready=s_rready[grant_idx]; all other s_rvalid=0.
  - The s_r* payload is a combinational pass-through of m_r*.
- DATA beat handling:
  - A beat transfers on m_rvalid & m_rready; the 9-bit beat counter increments per beat.
  - On a beat with m_rlast=1, go to IDLE.
  - Re-arbitration happens in the next IDLE cycle, so the minimum gap between bursts is 1 idle cycle.
- Outside DATA: m_rready=0. A stray m_rvalid stalls and is never forwarded.
- Beat check:
  - Error if m_rlast=1 on a beat where counter != latched arlen.
  - Error if m_rlast=0 on the beat where counter == latched arlen.
  - On error, protocol_err sets and stays 1 until reset. A short burst still ends at rlast; a long burst continues until rlast.
- rresp is passed through untouched; SLVERR/DECERR is not an arbiter error.
- Fairness: a master requesting continuously gets at most one grant per NUM_MASTERS grants while others also request.
- busy=1 in ADDR and DATA.

Test Plan:
- Single request: s_arvalid[2]=1, araddr=0x1000, arlen=3, slave arready=1 -> s_arready[2] pulses once; m_araddr=0x1000 one cycle later; 4 beats reach master 2 only, ending on rlast; busy drops; protocol_err=0.
- Round-robin: all 4 masters request continuously with arlen=0 -> grant order 0,1,2,3,0,1; each grant separated by the ADDR+DATA+IDLE cycles.
- Backpressure: m_arready low 5 cycles -> m_arvalid and payload stable all 5 cycles. Then s_rready[1]=0 for 3 cycles mid-burst -> m_rready=0 for those cycles, and no beats are lost or duplicated.
- Beat error: arlen=3, slave asserts rlast on beat index 1 -> protocol_err=1 after that beat; FSM returns to IDLE; the next burst completes normally with protocol_err still 1.
- Stray data: m_rvalid=1 while in IDLE with no requests -> m_rready=0, all s_rvalid=0, state unchanged.
- Reset mid-burst: areset=1 after beat 2 of arlen=7 -> next cycle all outputs at reset values; the next request from master 3 still sees master 0 top priority, and master 3 is granted if it is the sole requester.
